// File: rtl/selector_pipe.sv
// selector_pipe: registered N-way lane selector with valid/ready handshake,
// 2-entry skid buffer, out-of-range flagging and synchronous flush.
module selector_pipe #(
    parameter int N_IN = 8,
    parameter int WIDTH = 32,
    parameter int SEL_W = 3,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int NS = 1 << SEL_W;
    localparam int EW = WIDTH + SEL_W + 1;

    // One precomputed {word, sel, err} entry per select code; unused codes map to DEFAULT_VAL.
    logic [EW-1:0] lane_e [NS];
    for (genvar k = 0; k < NS; k++) begin : g_lane
        if (k < N_IN) begin : g_in
            assign lane_e[k] = {in_data[k*WIDTH +: WIDTH], SEL_W'(k), 1'b0};
        end else begin : g_def
            assign lane_e[k] = {DEFAULT_VAL, SEL_W'(k), 1'b1};
        end
    end

    logic [EW-1:0] new_e, out_e, skd_e;
    logic          out_v, skd_v, accept, pop;

    assign new_e    = lane_e[sel];
    assign in_ready = !rst && !skd_v;
    assign accept   = in_valid && in_ready;
    assign pop      = out_v && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v <= 1'b0;
            skd_v <= 1'b0;
            out_e <= '0;
            skd_e <= '0;
        end else if (flush) begin
            out_v <= 1'b0;
            skd_v <= 1'b0;
        end else if (pop && skd_v) begin
            out_e <= skd_e;
            skd_v <= 1'b0;
        end else if (accept && (!out_v || pop)) begin
            out_e <= new_e;
            out_v <= 1'b1;
        end else if (accept) begin
            skd_e <= new_e;
            skd_v <= 1'b1;
        end else if (pop) begin
            out_v <= 1'b0;
        end
    end

    assign out_valid = out_v;
    assign out_data  = out_e[EW-1 -: WIDTH];
    assign out_sel   = out_e[SEL_W:1];
    assign out_err   = out_e[0];
endmodule

// File: tb/tb_selector_pipe.sv
// tb_selector_pipe: directed and randomised checks of selector_pipe against a depth-2 FIFO model.
module tb_selector_pipe;
    logic         clk = 0, rst = 1;
    logic         fl8 = 0, iv8 = 0, or8 = 0, ir8, ov8, oe8;
    logic [2:0]   s8 = 0, os8;
    logic [255:0] d8;
    logic [31:0]  od8;
    logic         fl5 = 0, iv5 = 0, or5 = 0, ir5, ov5, oe5;
    logic [2:0]   s5 = 0, os5;
    logic [159:0] d5;
    logic [31:0]  od5;
    int           n = 0, fails = 0;
    logic [35:0]  q[$];

    always #5 clk = ~clk;

    selector_pipe #(.N_IN(8), .WIDTH(32), .SEL_W(3), .DEFAULT_VAL(32'h0)) u8 (
        .clk(clk), .rst(rst), .flush(fl8), .in_data(d8), .sel(s8), .in_valid(iv8),
        .in_ready(ir8), .out_data(od8), .out_sel(os8), .out_err(oe8),
        .out_valid(ov8), .out_ready(or8));

    selector_pipe #(.N_IN(5), .WIDTH(32), .SEL_W(3), .DEFAULT_VAL(32'hDEAD_BEEF)) u5 (
        .clk(clk), .rst(rst), .flush(fl5), .in_data(d5), .sel(s5), .in_valid(iv5),
        .in_ready(ir5), .out_data(od5), .out_sel(os5), .out_err(oe5),
        .out_valid(ov5), .out_ready(or5));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d8[k*32 +: 32] = 32'h1000_0000 + k;
        for (int k = 0; k < 5; k++) d5[k*32 +: 32] = 32'h1000_0000 + k;
        #1;
        chk("rst_in_ready", ir8, 0);
        chk("rst_out_valid", ov8, 0);
        cyc(); cyc();
        rst = 0;
        #1;
        chk("post_rst_in_ready", ir8, 1);
        // stream, then reset mid-stream
        iv8 = 1; s8 = 2; or8 = 1;
        cyc();
        chk("pre_rst_valid", ov8, 1);
        chk("pre_rst_data", od8, 32'h1000_0002);
        rst = 1;
        #1;
        chk("async_rst_valid", ov8, 0);
        chk("async_rst_data", od8, 0);
        chk("async_rst_ready", ir8, 0);
        iv8 = 0;
        cyc();
        rst = 0;
        #1;
        chk("release_ready", ir8, 1);
        iv8 = 1; s8 = 3;
        cyc();
        iv8 = 0;
        chk("sel3_valid", ov8, 1);
        chk("sel3_data", od8, 32'h1000_0003);
        chk("sel3_sel", os8, 3);
        chk("sel3_err", oe8, 0);
        cyc();
        chk("drain_valid", ov8, 0);
        // back-to-back
        for (int i = 0; i < 8; i++) begin
            iv8 = 1; s8 = 3'(i);
            chk("b2b_ready", ir8, 1);
            cyc();
            chk("b2b_valid", ov8, 1);
            chk("b2b_data", od8, 32'h1000_0000 + i);
        end
        iv8 = 0;
        cyc();
        chk("b2b_end_valid", ov8, 0);
        // backpressure
        or8 = 0; iv8 = 1; s8 = 1;
        cyc();
        chk("bp_ready1", ir8, 1);
        s8 = 2;
        cyc();
        iv8 = 0;
        chk("bp_ready2", ir8, 0);
        chk("bp_data1", od8, 32'h1000_0001);
        cyc();
        chk("bp_hold_data", od8, 32'h1000_0001);
        chk("bp_hold_sel", os8, 1);
        or8 = 1;
        cyc();
        chk("bp_pop_data2", od8, 32'h1000_0002);
        chk("bp_pop_ready", ir8, 1);
        cyc();
        chk("bp_empty", ov8, 0);
        // flush with both entries full
        or8 = 0; iv8 = 1; s8 = 4;
        cyc();
        s8 = 5;
        cyc();
        s8 = 6; fl8 = 1;
        chk("fl_full_ready", ir8, 0);
        cyc();
        fl8 = 0; iv8 = 0;
        chk("fl_valid", ov8, 0);
        chk("fl_ready", ir8, 1);
        or8 = 1;
        cyc();
        chk("fl_nothing", ov8, 0);
        // out-of-range on N_IN=5
        iv5 = 1; s5 = 6; or5 = 1;
        cyc();
        chk("oor_data", od5, 32'hDEAD_BEEF);
        chk("oor_sel", os5, 6);
        chk("oor_err", oe5, 1);
        s5 = 4;
        cyc();
        iv5 = 0;
        chk("lane4_data", od5, 32'h1000_0004);
        chk("lane4_err", oe5, 0);
        // randomised against a depth-2 FIFO reference
        for (int c = 0; c < 10000; c++) begin
            logic acc, pp;
            chk("rnd_ready", ir8, q.size() < 2);
            chk("rnd_valid", ov8, q.size() > 0);
            if (q.size() > 0) chk("rnd_entry", {od8, os8, oe8}, q[0]);
            for (int k = 0; k < 8; k++) d8[k*32 +: 32] = $urandom;
            s8 = 3'($urandom_range(0, 7));
            iv8 = 1'($urandom_range(0, 1));
            or8 = ($urandom_range(0, 3) != 0);
            fl8 = ($urandom_range(0, 49) == 0);
            #1;
            acc = iv8 && q.size() < 2;
            pp = or8 && q.size() > 0;
            if (fl8) q.delete();
            else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back({d8[s8*32 +: 32], s8, 1'b0});
            end
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule

// File: doc/selector_pipe.md
Name: selector_pipe

Overview:
- Parametrised, registered N-way word selector for the mono-cycle MIPS datapath. Intended for write-back and ALU operand source selection once the datapath is pipelined.
- Selects one WIDTH-bit lane from N_IN packed inputs using `sel`. Registers the result behind a valid/ready handshake, with a 2-entry skid buffer for full throughput.
- Flags out-of-range selects. Supports a synchronous flush for pipeline squash.

Parameters:
- N_IN, 8, number of input lanes (2..64).
- WIDTH, 32, bits per lane.
- SEL_W, 3, select width; constraint 2^SEL_W >= N_IN.
- DEFAULT_VAL, 0, WIDTH-bit value output when `sel` >= N_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_data  input  N_IN*WIDTH  packed lanes; lane k = in_data[k*WIDTH +: WIDTH].
- sel  input  SEL_W  lane select, sampled with in_data.
- in_valid  input  1  upstream offers in_data/sel.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected word (registered).
- out_sel  output  SEL_W  `sel` that produced out_data.
- out_err  output  1  1 when out_sel >= N_IN.
- out_valid  output  1  out_data/out_sel/out_err are valid.
- out_ready  input  1  downstream consumes this cycle.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, out_err=0, skid entry empty. in_ready=0 while rst=1 and 1 in the first cycle after release.
- Selection (combinational, before storage):
  - sel < N_IN: word = lane[sel], err=0.
  - sel >= N_IN: word = DEFAULT_VAL, err=1.
  - {word, sel, err} is captured as one entry.
- Storage:
  - Output register OUT holds {valid, word, sel, err}; it drives the out_* ports.
  - Skid register SKD holds the same fields.
- Handshakes:
  - in_ready = !SKD.valid; it is a function of registers only, with no combinational in-to-out path.
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Next state, evaluated per clock edge with flush=0:
  - pop & SKD.valid: OUT<=SKD. SKD<=accept ? new : empty (accept cannot occur while SKD is full, so SKD is cleared).
  - accept & (!OUT.valid | pop) & !SKD.valid: OUT<=new.
  - accept & OUT.valid & !pop: SKD<=new.
  - pop & !accept & !SKD.valid: OUT.valid<=0. Data fields hold their last value.
  - Otherwise: hold.
- Latency and throughput:
  - Accepted entry appears on out_* exactly 1 cycle after the accept edge when OUT was free or popping.
  - Sustained throughput is 1 entry/cycle with out_ready=1.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- Stall behaviour:
  - With out_ready=0, at most 2 entries are held (OUT, then SKD); in_ready falls the cycle after SKD fills.
  - out_data and out_sel are stable while out_valid=1 and out_ready=0.
- Flush=1 (synchronous):
  - OUT.valid<=0 and SKD.valid<=0 at the edge; any accept in the same cycle is discarded.
  - Data fields are not cleared; in_ready=1 the next cycle.
  - Flush overrides pop and accept.
- Simultaneous pop and accept with SKD empty: the new entry replaces OUT in the same edge (no bubble).
- Reset mid-operation: all entries are lost immediately and the outputs take reset values asynchronously.
- SEL_W greater than needed: unused codes are treated as out-of-range (err=1).

Test Plan:
- Reset, then streaming, N_IN=8, WIDTH=32, lane k=0x1000_0000+k: assert rst mid-stream -> out_valid=0, out_data=0 immediately; after release in_ready=1. Then send sel=3, out_ready=1 -> next cycle out_data=0x1000_0003, out_sel=3, out_err=0, out_valid=1.
- Back-to-back sel=0..7 with out_ready=1 -> in_ready stays 1, eight consecutive out_valid cycles, out_data=0x1000_0000..0x1000_0007 in order.
- Backpressure: out_ready=0, push sel=1,2 -> in_ready=0 after the second accept and out_data holds 0x1000_0001. Raise out_ready -> outputs 0x1000_0001 then 0x1000_0002; in_ready returns to 1 the cycle after the first pop.
- Out-of-range (N_IN=5, SEL_W=3, DEFAULT_VAL=0xDEAD_BEEF): sel=6 -> out_data=0xDEAD_BEEF, out_sel=6, out_err=1. Next sel=4 -> lane 4 value, out_err=0.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and same-cycle inputs never appear at the output.
- Randomised valid/ready toggling against a reference queue model -> zero ordering or data mismatches over 10k cycles.
